// File: rtl/led_uart_tx_pkg.sv
// led_uart_tx_pkg: shared UART state encodings and line levels for led_uart_tx.
package led_uart_tx_pkg;
  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uartState_t;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter, restarted at each frame start.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iClear,
  output logic oTick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] count;
  assign oTick = count == LAST;
  always_ff @(posedge Clock)
    count <= (Reset || iClear || oTick) ? '0 : count + W'(1);
endmodule

// File: rtl/led_uart_tx.sv
// led_uart_tx: sends the LED byte as one UART frame whenever it differs from the last byte sent.
// Define LED_UART_PARITY_EN for 8E1 frames; the default build is 8N1.
module led_uart_tx
  import led_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  output logic       oTx,
  output logic       oBusy
);
  uartState_t state;
  logic [7:0] shift, lastSent;
  logic [2:0] bitIdx;
  logic tick, start;
`ifdef LED_UART_PARITY_EN
  logic parity;
`endif
  // Change is only looked at in IDLE, so values seen mid-frame collapse to the latest one.
  assign start = state == UART_IDLE && iData != lastSent;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .Clock(Clock),
    .Reset(Reset),
    .iClear(start),
    .oTick(tick)
  );
  always_ff @(posedge Clock)
    if (Reset) begin
      state    <= UART_IDLE;
      oTx      <= UART_IDLE_LEVEL;
      oBusy    <= 1'b0;
      lastSent <= 8'h00;
      shift    <= 8'h00;
      bitIdx   <= 3'd0;
`ifdef LED_UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else
      case (state)
        UART_IDLE:
          if (start) begin
            shift    <= iData;
            lastSent <= iData;
            bitIdx   <= 3'd0;
            state    <= UART_START;
            oTx      <= 1'b0;
            oBusy    <= 1'b1;
`ifdef LED_UART_PARITY_EN
            parity   <= ^iData;
`endif
          end
        UART_START:
          if (tick) begin
            state <= UART_DATA;
            oTx   <= shift[0];
          end
        UART_DATA:
          if (tick) begin
            if (bitIdx == 3'd7) begin
`ifdef LED_UART_PARITY_EN
              state <= UART_PARITY;
              oTx   <= parity;
`else
              state <= UART_STOP;
              oTx   <= UART_IDLE_LEVEL;
`endif
            end else begin
              shift  <= shift >> 1;
              bitIdx <= bitIdx + 3'd1;
              oTx    <= shift[1];
            end
          end
`ifdef LED_UART_PARITY_EN
        UART_PARITY:
          if (tick) begin
            state <= UART_STOP;
            oTx   <= UART_IDLE_LEVEL;
          end
`endif
        UART_STOP:
          if (tick) begin
            state <= UART_IDLE;
            oBusy <= 1'b0;
          end
        default: begin
          state <= UART_IDLE;
          oTx   <= UART_IDLE_LEVEL;
          oBusy <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_led_uart_tx.sv
// tb_led_uart_tx: directed and random stimulus against a frame-level waveform model of led_uart_tx.
module tb_led_uart_tx;
  localparam int CPB = 4;
`ifdef LED_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  logic Clock = 1'b0, Reset = 1'b1;
  logic [7:0] iData = 8'h00;
  logic oTx, oBusy;
  int checks = 0, fails = 0;
  int starts = 0, busyCycles = 0;
  logic prevBusy = 1'b0;
  logic [1:0] expQ[$];
  logic txLog[$];
  logic [7:0] lastSent = 8'h00;

  led_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iData(iData),
    .oTx(oTx),
    .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  task automatic checkInt(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected per-cycle {busy, tx} for one frame (LSB first), plus the return-to-idle cycle.
  task automatic pushFrame(input logic [7:0] d);
    logic [NBITS-1:0] bits;
`ifdef LED_UART_PARITY_EN
    bits = {1'b1, ^d, d, 1'b0};
`else
    bits = {1'b1, d, 1'b0};
`endif
    for (int b = 0; b < NBITS; b++)
      for (int c = 0; c < CPB; c++) expQ.push_back({1'b1, bits[b]});
    expQ.push_back(2'b01);
  endtask

  task automatic cycle();
    logic [1:0] e;
    if (Reset) begin
      expQ.delete();
      lastSent = 8'h00;
    end else if (expQ.size() == 0 && iData != lastSent) begin
      pushFrame(iData);
      lastSent = iData;
    end
    e = (expQ.size() != 0) ? expQ.pop_front() : 2'b01;
    @(posedge Clock);
    #1;
    checkInt("oTx", int'(oTx), int'(e[0]));
    checkInt("oBusy", int'(oBusy), int'(e[1]));
    if (oBusy && !prevBusy) starts++;
    if (oBusy) busyCycles++;
    prevBusy = oBusy;
    txLog.push_back(oTx);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clearStats();
    starts = 0;
    busyCycles = 0;
    txLog.delete();
  endtask

  initial begin
    Reset = 1'b1;
    run(3);
    Reset = 1'b0;
    clearStats();
    run(100);
    checkInt("zeroAfterReset.starts", starts, 0);

    clearStats();
    iData = 8'hA5;
    run(FRAME + 5);
    checkInt("a5.starts", starts, 1);
    checkInt("a5.busyCycles", busyCycles, FRAME);
    checkInt("a5.startBit", int'(txLog[0]), 0);
    checkInt("a5.bit0", int'(txLog[CPB]), 1);
    checkInt("a5.bit1", int'(txLog[2*CPB]), 0);

    clearStats();
    iData = 8'h5A;
    run(12);
    iData = 8'h01;
    run(1);
    iData = 8'h3C;
    run(2 * FRAME + 20);
    checkInt("latestOnly.starts", starts, 2);
    checkInt("latestOnly.busyCycles", busyCycles, 2 * FRAME);
    checkInt("latestOnly.gapIdle", int'(txLog[FRAME]), 1);

    clearStats();
    iData = 8'hC3;
    run(15);
    Reset = 1'b1;
    run(1);
    checkInt("midReset.tx", int'(oTx), 1);
    checkInt("midReset.busy", int'(oBusy), 0);
    Reset = 1'b0;
    iData = 8'h3C;
    clearStats();
    run(FRAME + 10);
    checkInt("afterReset.starts", starts, 1);
    checkInt("afterReset.busyCycles", busyCycles, FRAME);

    clearStats();
    iData = 8'h5A;
    run(200);
    checkInt("held.starts", starts, 1);

`ifdef LED_UART_PARITY_EN
    clearStats();
    iData = 8'h07;
    run(FRAME + 5);
    checkInt("par07.bit", int'(txLog[9*CPB]), 1);
    checkInt("par07.busyCycles", busyCycles, 44);
    clearStats();
    iData = 8'h03;
    run(FRAME + 5);
    checkInt("par03.bit", int'(txLog[9*CPB]), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) iData = 8'($urandom);
      Reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    Reset = 1'b0;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
